imem_loader: RTL
================

// Module: imem_loader
// PURPOSE
//  Write-side companion of the instruction memory: receives a byte-serial program image,
//  assembles 16-bit instructions and writes them into the instruction RAM at ascending
//  addresses from 0. Holds the CPU (cpu_hold) from start until the image is accepted
//  or rejected. Sits between the host/UART byte stream and the imem write port.
// PARAMETERS
//  DEPTH      256    instruction RAM depth in words; image length N > DEPTH is an error
//  SYNC_BYTE  8'hA5  frame start marker
// PORTS
//  clk       in   1   system clock, all logic on rising edge
//  rst       in   1   synchronous, active-high reset
//  start     in   1   pulse: arm loader (honoured only in IDLE, DONE, ERR)
//  in_valid  in   1   byte-stream valid
//  in_data   in   8   byte-stream data
//  in_ready  out  1   byte accepted on a clk edge where in_valid && in_ready
//  wr_en     out  1   imem write strobe, exactly one cycle per word
//  wr_addr   out  16  imem word address
//  wr_data   out  16  imem write data
//  cpu_hold  out  1   keep CPU/PC stalled while 1
//  done      out  1   sticky: image loaded and checksum good
//  err       out  1   sticky: image rejected
// BEHAVIOUR
//  Frame: SYNC_BYTE, LEN_HI, LEN_LO (N = word count), N words high byte first, CSUM.
//  CSUM = XOR of all 2N data bytes (length bytes excluded).
//  Reset: state IDLE; in_ready, wr_en, cpu_hold, done, err = 0; wr_addr, wr_data = 0;
//    csum accumulator = 0. rst mid-frame aborts immediately; the partial image stays in RAM.
//  States: IDLE, SYNC, LEN_HI, LEN_LO, D_HI, D_LO, WRITE, CSUM, DONE, ERR.
//  IDLE --start--> SYNC. On entry: cpu_hold=1, done=err=0, wr_addr=0, csum=0.
//  SYNC: in_ready=1. Bytes != SYNC_BYTE are discarded silently. SYNC_BYTE -> LEN_HI.
//  LEN_HI, LEN_LO: in_ready=1; capture N. After LEN_LO:
//    N=0 -> CSUM; N>DEPTH -> ERR; otherwise -> D_HI.
//  D_HI: latch high byte. D_LO: latch low byte -> WRITE. Both XOR each byte into csum.
//  WRITE: in_ready=0, wr_en=1 for one cycle with wr_addr/wr_data valid. Next cycle:
//    wr_addr+1 and words_left-1; words_left==0 -> CSUM, else -> D_HI.
//  Latency: last data byte accepted at edge t; wr_en is high during cycle t+1.
//  CSUM: in_ready=1; byte == csum -> DONE (done=1, cpu_hold=0); mismatch -> ERR.
//  ERR: err=1; cpu_hold stays 1 (CPU must not run a bad image); in_ready=0.
//  DONE/ERR are sticky until start (re-arm, same as IDLE entry) or rst.
//  start in SYNC..CSUM is ignored. in_valid low stalls any receive state indefinitely.
//  in_ready=0 in IDLE, WRITE, DONE, ERR; in_data is ignored there.
//  wr_addr is 16 bit and never exceeds DEPTH-1, because the N>DEPTH check comes first.
//  wr_data holds its last value when wr_en=0.
// STRUCTURE
//  Shared package (imem_pkg): state enum encoding, SYNC_BYTE default, IMEM_DEPTH,
//    INSTR_W=16. The CPU-side instruction memory also uses these.
//  Single module: FSM plus counters. No sub-module; byte assembly is two registers.
// TESTING
//  1 start; A5,00,03,96,3C,92,0F,B6,7B,FA -> wr_en x3: (0,963C),(1,920F),(2,B67B);
//    done=1, cpu_hold=0, err=0.
//  2 Send 00,FF,5A before A5, then the frame from test 1 -> junk ignored, identical writes, done=1.
//  3 A5,00,00,00 -> no wr_en, done=1. Same with CSUM 01 -> err=1, cpu_hold=1.
//  4 A5,01,01 (N=257, DEPTH=256) -> err=1 right after LEN_LO; no wr_en; later bytes ignored.
//  5 Frame from test 1 with CSUM 00 -> three writes, then err=1, cpu_hold=1; start re-arms
//    (err=0, wr_addr=0).
//  6 in_valid toggled randomly across test 1, plus rst asserted after the 2nd write -> all
//    outputs 0 and state IDLE next cycle; start plus the full frame then succeeds.

Source files
------------

// File: rtl/imem_pkg.sv
// Shared definitions for the instruction memory and its byte-serial loader.
package imem_pkg;

    // Instruction RAM geometry, shared with the CPU-side memory.
    localparam int          IMEM_DEPTH        = 256;
    localparam int          INSTR_W           = 16;

    // Default frame start marker.
    localparam logic [7:0]  SYNC_BYTE_DEFAULT = 8'hA5;

    // Loader FSM encoding.
    typedef logic [3:0] state_t;

    localparam state_t ST_IDLE   = 4'd0;
    localparam state_t ST_SYNC   = 4'd1;
    localparam state_t ST_LEN_HI = 4'd2;
    localparam state_t ST_LEN_LO = 4'd3;
    localparam state_t ST_D_HI   = 4'd4;
    localparam state_t ST_D_LO   = 4'd5;
    localparam state_t ST_WRITE  = 4'd6;
    localparam state_t ST_CSUM   = 4'd7;
    localparam state_t ST_DONE   = 4'd8;
    localparam state_t ST_ERR    = 4'd9;

endpackage

// File: rtl/imem_loader.sv
// Byte-serial program loader: parses SYNC/LEN/data/CSUM frames, writes 16-bit
// instructions to the imem write port and holds the CPU until the image is judged.
module imem_loader
    import imem_pkg::*;
#(
    parameter int         DEPTH     = IMEM_DEPTH,
    parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEFAULT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               in_valid,
    input  logic [7:0]         in_data,
    output logic               in_ready,
    output logic               wr_en,
    output logic [15:0]        wr_addr,
    output logic [INSTR_W-1:0] wr_data,
    output logic               cpu_hold,
    output logic               done,
    output logic               err
);

    // Depth widened so a full 16-bit length can be compared without wrap.
    localparam logic [16:0] DEPTH_W = 17'(DEPTH);

    state_t      state;
    logic [7:0]  len_hi;
    logic [7:0]  hi_byte;
    logic [7:0]  csum;
    logic [15:0] words_left;

    logic        in_fire;
    logic [15:0] len_word;
    logic        len_too_big;

    // Handshake and write strobe are pure functions of the current state.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        in_ready = 1'b0;
        wr_en    = 1'b0;
        case (state)
            ST_SYNC, ST_LEN_HI, ST_LEN_LO,
            ST_D_HI, ST_D_LO, ST_CSUM: in_ready = 1'b1;
            ST_WRITE:                  wr_en    = 1'b1;
            default:                   ;
        endcase
    end

    assign in_fire     = in_valid && in_ready;
    assign len_word    = {len_hi, in_data};
    assign len_too_big = {1'b0, len_word} > DEPTH_W;

    // Frame parser, address/word counters and sticky status flags.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            state      <= ST_IDLE;
            len_hi     <= '0;
            hi_byte    <= '0;
            csum       <= '0;
            words_left <= '0;
            wr_addr    <= '0;
            wr_data    <= '0;
            cpu_hold   <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE, ST_ERR: begin
                    if (start) begin
                        state    <= ST_SYNC;
                        cpu_hold <= 1'b1;
                        done     <= 1'b0;
                        err      <= 1'b0;
                        wr_addr  <= '0;
                        csum     <= '0;
                    end
                end
                ST_SYNC: begin
                    if (in_fire && in_data == SYNC_BYTE) state <= ST_LEN_HI;
                end
                ST_LEN_HI: begin
                    if (in_fire) begin
                        len_hi <= in_data;
                        state  <= ST_LEN_LO;
                    end
                end
                ST_LEN_LO: begin
                    if (in_fire) begin
                        words_left <= len_word;
                        if (len_word == 16'd0) begin
                            state <= ST_CSUM;
                        end else if (len_too_big) begin
                            state <= ST_ERR;
                            err   <= 1'b1;
                        end else begin
                            state <= ST_D_HI;
                        end
                    end
                end
                ST_D_HI: begin
                    if (in_fire) begin
                        hi_byte <= in_data;
                        csum    <= csum ^ in_data;
                        state   <= ST_D_LO;
                    end
                end
                ST_D_LO: begin
                    if (in_fire) begin
                        wr_data <= {hi_byte, in_data};
                        csum    <= csum ^ in_data;
                        state   <= ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    // The address stops on the last word so it never leaves the RAM range.
                    words_left <= words_left - 16'd1;
                    if (words_left == 16'd1) begin
                        state <= ST_CSUM;
                    end else begin
                        wr_addr <= wr_addr + 16'd1;
                        state   <= ST_D_HI;
                    end
                end
                ST_CSUM: begin
                    if (in_fire) begin
                        if (in_data == csum) begin
                            state    <= ST_DONE;
                            done     <= 1'b1;
                            cpu_hold <= 1'b0;
                        end else begin
                            state <= ST_ERR;
                            err   <= 1'b1;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
